// File: rtl/mm_pkg.sv
// Shared constants and state encoding for the array-multiplier byte interface.
// Byte order (LSB first) and word packing are common to the operand loader and result TX.
package mm_pkg;

    localparam int unsigned N_ELEM  = 9;
    localparam int unsigned ELEM_W  = 18;
    localparam int unsigned BPE     = 3;
    localparam int unsigned FLAT_W  = N_ELEM * ELEM_W;
    localparam int unsigned ELEM_CW = 4;
    localparam int unsigned BYTE_CW = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StDone = 2'd2,
        StChk  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/mm_result_tx_if.sv
// Byte-stream valid/ready handshake between the result transmitter and its consumer.
interface mm_result_tx_if;

    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/mm_byte_sel.sv
// Combinational byte picker: byte b (LSB first) of word e from the packed shadow register.
module mm_byte_sel
    import mm_pkg::*;
(
    input  logic [FLAT_W-1:0]  shadow_i,
    input  logic [ELEM_CW-1:0] elem_i,
    input  logic [BYTE_CW-1:0] byte_i,
    output logic [7:0]         byte_o
);

    logic [ELEM_W-1:0]  word;
    logic [BPE*8-1:0]   padded;

    always_comb begin
        word = '0;
        for (int i = 0; i < int'(N_ELEM); i++) begin
            if (elem_i == ELEM_CW'(i)) begin
                word = shadow_i[i*ELEM_W +: ELEM_W];
            end
        end
    end

    // Top bits of the last byte are zero-padded.
    assign padded = {{(BPE * 8 - ELEM_W){1'b0}}, word};

    always_comb begin
        byte_o = '0;
        for (int b = 0; b < int'(BPE); b++) begin
            if (byte_i == BYTE_CW'(b)) begin
                byte_o = padded[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/mm_result_tx.sv
// Result transmitter: snapshots C on start and streams it LSB byte first over valid/ready.
// Optional trailing XOR checksum byte when MM_RESULT_TX_CHECKSUM_EN is defined.
module mm_result_tx
    import mm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [FLAT_W-1:0] c_flat,
    mm_result_tx_if.master    tx,
    output logic              done
);

    tx_state_e            state_q, state_d;
    logic [FLAT_W-1:0]    shadow_q, shadow_d;
    logic [ELEM_CW-1:0]   elem_q, elem_d;
    logic [BYTE_CW-1:0]   byte_q, byte_d;
    logic [7:0]           sel_byte;
    logic                 xfer;
`ifdef MM_RESULT_TX_CHECKSUM_EN
    logic [7:0]           xor_q, xor_d;
`endif

    mm_byte_sel u_byte_sel (
        .shadow_i (shadow_q),
        .elem_i   (elem_q),
        .byte_i   (byte_q),
        .byte_o   (sel_byte)
    );

    assign xfer = tx.out_valid & tx.out_ready;

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        elem_d   = elem_q;
        byte_d   = byte_q;
`ifdef MM_RESULT_TX_CHECKSUM_EN
        xor_d    = xor_q;
`endif
        case (state_q)
            StIdle: begin
                if (start) begin
                    shadow_d = c_flat;
                    elem_d   = '0;
                    byte_d   = '0;
`ifdef MM_RESULT_TX_CHECKSUM_EN
                    xor_d    = '0;
`endif
                    state_d  = StSend;
                end
            end
            StSend: begin
                if (xfer) begin
`ifdef MM_RESULT_TX_CHECKSUM_EN
                    xor_d = xor_q ^ sel_byte;
`endif
                    if (byte_q == BYTE_CW'(BPE - 1)) begin
                        byte_d = '0;
                        if (elem_q == ELEM_CW'(N_ELEM - 1)) begin
                            elem_d = '0;
`ifdef MM_RESULT_TX_CHECKSUM_EN
                            state_d = StChk;
`else
                            state_d = StDone;
`endif
                        end else begin
                            elem_d = elem_q + 1'b1;
                        end
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
            end
`ifdef MM_RESULT_TX_CHECKSUM_EN
            StChk: begin
                if (xfer) begin
                    state_d = StDone;
                end
            end
`endif
            StDone: begin
                // Holding start keeps us here so the frame is not resent.
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            shadow_q <= '0;
            elem_q   <= '0;
            byte_q   <= '0;
`ifdef MM_RESULT_TX_CHECKSUM_EN
            xor_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            elem_q   <= elem_d;
            byte_q   <= byte_d;
`ifdef MM_RESULT_TX_CHECKSUM_EN
            xor_q    <= xor_d;
`endif
        end
    end

    // Outputs decode only registered state, so they clear as soon as reset asserts.
    always_comb begin
        tx.out_valid = 1'b0;
        tx.out_data  = '0;
        done         = 1'b0;
        case (state_q)
            StSend: begin
                tx.out_valid = 1'b1;
                tx.out_data  = sel_byte;
            end
`ifdef MM_RESULT_TX_CHECKSUM_EN
            StChk: begin
                tx.out_valid = 1'b1;
                tx.out_data  = xor_q;
            end
`endif
            StDone: done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mm_result_tx.sv
// Self-checking bench for mm_result_tx: randomized frames vs. a byte-queue reference model.
module tb_mm_result_tx;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [161:0] c_flat = '0;
    logic         done;
    int           total = 0;
    int           bad = 0;

    mm_result_tx_if tx_if ();

    mm_result_tx dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .c_flat (c_flat),
        .tx     (tx_if),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // mode 0: ready always 1; 1: random ready; 2: ready 1,0,0,1 while byte 13 (word 4) is offered
    task automatic run_frame(input int mode, input int abort_at, input int rewrite_at,
                             input bit drop_start);
        logic [7:0]  q[$];
        logic [7:0]  csum;
        logic [17:0] w;
        int          k;
        int          cyc;
        int          hold;
        bit          r;
        csum = 8'h00;
        for (int i = 0; i < 9; i++) begin
            w = c_flat[18*i +: 18];
            for (int b = 0; b < 3; b++) begin
                q.push_back(8'((w >> (8 * b)) & 18'hFF));
                csum = csum ^ q[q.size()-1];
            end
        end
`ifdef MM_RESULT_TX_CHECKSUM_EN
        q.push_back(csum);
`endif
        k = 0;
        cyc = 0;
        hold = 0;
        @(negedge clk);
        start = 1'b1;
        tx_if.out_ready = 1'b1;
        while (k < q.size() && k != abort_at && cyc < 400) begin
            @(negedge clk);
            cyc++;
            check_eq("valid", 32'(tx_if.out_valid), 32'd1);
            check_eq("data", 32'(tx_if.out_data), 32'(q[k]));
            check_eq("done_low", 32'(done), 32'd0);
            if (k == rewrite_at) c_flat = '1;
            if (drop_start && k == 5) start = 1'b0;
            case (mode)
                0: r = 1'b1;
                1: r = 1'($urandom_range(0, 1));
                default: begin
                    if (k == 13 && hold < 2) begin
                        r = 1'b0;
                        hold++;
                    end else begin
                        r = 1'b1;
                    end
                end
            endcase
            tx_if.out_ready = r;
            if (r) k++;
        end
        if (k == abort_at) return;
        if (k < q.size()) begin
            check_eq("timeout", 32'(k), 32'(q.size()));
            return;
        end
        if (mode == 0) check_eq("cycles", 32'(cyc), 32'(q.size()));
        if (mode == 2) check_eq("cycles_bp", 32'(cyc), 32'(q.size() + 2));
        @(negedge clk);
        check_eq("done_high", 32'(done), 32'd1);
        check_eq("valid_end", 32'(tx_if.out_valid), 32'd0);
        check_eq("data_end", 32'(tx_if.out_data), 32'd0);
        if (start) begin
            @(negedge clk);
            check_eq("no_resend_done", 32'(done), 32'd1);
            check_eq("no_resend_valid", 32'(tx_if.out_valid), 32'd0);
            start = 1'b0;
        end
        @(negedge clk);
        check_eq("done_drop", 32'(done), 32'd0);
        check_eq("idle_valid", 32'(tx_if.out_valid), 32'd0);
    endtask

    task automatic load_seq();
        for (int i = 0; i < 9; i++) c_flat[18*i +: 18] = 18'(i + 1);
    endtask

    initial begin
        tx_if.out_ready = 1'b0;
        // Reset held with start asserted.
        start = 1'b1;
        load_seq();
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_valid", 32'(tx_if.out_valid), 32'd0);
            check_eq("rst_data", 32'(tx_if.out_data), 32'd0);
            check_eq("rst_done", 32'(done), 32'd0);
        end
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Sequential words, full rate.
        run_frame(0, -1, -1, 1'b0);

        // Corner word values.
        for (int i = 0; i < 9; i++) c_flat[18*i +: 18] = 18'($urandom);
        c_flat[17:0] = 18'h3FFFF;
        c_flat[161:144] = 18'h20001;
        run_frame(0, -1, -1, 1'b0);

        // Backpressure during word 4.
        load_seq();
        run_frame(2, -1, -1, 1'b0);

        // Snapshot isolation, then reset mid-frame.
        load_seq();
        run_frame(0, 12, 10, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_valid", 32'(tx_if.out_valid), 32'd0);
        check_eq("async_data", 32'(tx_if.out_data), 32'd0);
        check_eq("async_done", 32'(done), 32'd0);
        start = 1'b0;
        load_seq();
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(0, -1, -1, 1'b0);

        // Randomized frames with random backpressure and start dropped mid-frame.
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 9; i++) c_flat[18*i +: 18] = 18'($urandom);
            run_frame(1, -1, (t % 2 == 0) ? 7 : -1, t[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
